// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog escalation stage.
package wdt_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWarn    = 2'd1,
    StReset   = 2'd2,
    StHoldoff = 2'd3
  } wdt_state_e;

  localparam logic [5:0] AddrCtrl   = 6'h0;
  localparam logic [5:0] AddrGrace  = 6'h1;
  localparam logic [5:0] AddrPulse  = 6'h2;
  localparam logic [5:0] AddrStatus = 6'h3;
  localparam logic [5:0] AddrAck    = 6'h4;

  localparam int unsigned PulseWidth = 8;

endpackage

// File: rtl/tqvp_stevej_wdt_escalator_if.sv
// TinyQV peripheral register bus between the CPU side and the escalator.
interface tqvp_stevej_wdt_escalator_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/tqvp_stevej_wdt_escalator.sv
// Watchdog escalation: warning irq, grace period, then a fixed-width system reset pulse.
module tqvp_stevej_wdt_escalator
  import wdt_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wdt_expired,
  tqvp_stevej_wdt_escalator_if.slave    bus,
  output logic                          irq_out,
  output logic                          sys_reset_out
);

  wdt_state_e            state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  en_q, en_d;
  logic                  rst_en_q, rst_en_d;
  logic [31:0]           grace_q, grace_d;
  logic [PulseWidth-1:0] pulse_q, pulse_d;
  logic [7:0]            count_q, count_d;
  logic                  cause_q, cause_d;

  logic        wr_en, wr_ctrl, wr_grace, wr_pulse, wr_status, wr_ack, wr_disable;
  logic [31:0] pulse_len;
  logic        unused_read;

  assign unused_read = ^bus.data_read_n;

  assign wr_en      = (bus.data_write_n != 2'b11);
  assign wr_ctrl    = wr_en && (bus.address == AddrCtrl);
  assign wr_grace   = wr_en && (bus.address == AddrGrace);
  assign wr_pulse   = wr_en && (bus.address == AddrPulse);
  assign wr_status  = wr_en && (bus.address == AddrStatus);
  assign wr_ack     = wr_en && (bus.address == AddrAck);
  assign wr_disable = wr_ctrl && !bus.data_in[0];

  assign pulse_len = (pulse_q == '0) ? 32'd1 : {{(32 - PulseWidth){1'b0}}, pulse_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      rst_en_q <= 1'b0;
      grace_q  <= '0;
      pulse_q  <= '0;
      count_q  <= '0;
      cause_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      rst_en_q <= rst_en_d;
      grace_q  <= grace_d;
      pulse_q  <= pulse_d;
      count_q  <= count_d;
      cause_q  <= cause_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    rst_en_d = rst_en_q;
    grace_d  = grace_q;
    pulse_d  = pulse_q;
    count_d  = count_q;
    cause_d  = cause_q;

    if (wr_ctrl) begin
      en_d     = bus.data_in[0];
      rst_en_d = bus.data_in[1];
    end
    if (wr_grace) grace_d = bus.data_in;
    if (wr_pulse) pulse_d = bus.data_in[PulseWidth-1:0];
    // Clear first so a same-cycle increment or cause set below overrides it.
    if (wr_status) begin
      count_d = '0;
      cause_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (en_q && wdt_expired) begin
          state_d = StWarn;
          cnt_d   = grace_q;
          count_d = (count_q == 8'hff) ? count_q : count_q + 8'd1;
        end
      end
      StWarn: begin
        if (wr_disable) begin
          state_d = StIdle;
        end else if (wr_ack) begin
          state_d = StHoldoff;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (rst_en_q) begin
          state_d = StReset;
          cnt_d   = pulse_len;
          cause_d = 1'b1;
        end
      end
      StReset: begin
        // Pulse always runs to completion; ack and disable are ignored here.
        cnt_d = cnt_q - 32'd1;
        if (cnt_q == 32'd1) state_d = StHoldoff;
      end
      StHoldoff: begin
        if (wr_disable || !wdt_expired) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.data_out = '0;
    case (bus.address)
      AddrCtrl:   bus.data_out = {30'b0, rst_en_q, en_q};
      AddrGrace:  bus.data_out = grace_q;
      AddrPulse:  bus.data_out = {{(32 - PulseWidth){1'b0}}, pulse_q};
      AddrStatus: bus.data_out = {14'b0, state_q, count_q, 7'b0, cause_q};
      default:    bus.data_out = '0;
    endcase
  end

  assign bus.data_ready = 1'b1;
  assign irq_out        = (state_q == StWarn);
  assign sys_reset_out  = (state_q == StReset);

endmodule

// File: tb/tb_tqvp_stevej_wdt_escalator.sv
// Directed bench for the watchdog escalator; outputs sampled on the falling edge.
module tb_tqvp_stevej_wdt_escalator;
  import wdt_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic wdt_expired;
  logic irq_out, sys_reset_out;
  int   checks = 0;
  int   errors = 0;

  tqvp_stevej_wdt_escalator_if bus ();

  tqvp_stevej_wdt_escalator dut (
    .clk          (clk),
    .rst          (rst),
    .wdt_expired  (wdt_expired),
    .bus          (bus),
    .irq_out      (irq_out),
    .sys_reset_out(sys_reset_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    bus.address      = a;
    bus.data_in      = d;
    bus.data_write_n = 2'b00;
    tick();
    bus.data_write_n = 2'b11;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    chk(tag, bus.data_out, exp);
  endtask

  initial begin
    int  n;
    logic seen;

    rst              = 1'b1;
    wdt_expired      = 1'b0;
    bus.address      = '0;
    bus.data_in      = '0;
    bus.data_write_n = 2'b11;
    bus.data_read_n  = 2'b11;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("reset_irq", {31'b0, irq_out}, 32'd0);
    chk("reset_sysrst", {31'b0, sys_reset_out}, 32'd0);
    chk("data_ready", {31'b0, bus.data_ready}, 32'd1);
    rd_chk("reset_ctrl", AddrCtrl, 32'd0);
    rd_chk("reset_grace", AddrGrace, 32'd0);
    rd_chk("reset_status", AddrStatus, 32'd0);

    // Normal escalation: G=5, P=3
    wr(AddrGrace, 32'd5);
    wr(AddrPulse, 32'd3);
    wr(AddrCtrl, 32'd3);
    rd_chk("ctrl_rb", AddrCtrl, 32'd3);
    rd_chk("grace_rb", AddrGrace, 32'd5);
    rd_chk("unmapped_rd", 6'h5, 32'd0);
    rd_chk("ack_rd", AddrAck, 32'd0);
    wdt_expired = 1'b1;
    tick();
    chk("trig_latency", {31'b0, irq_out}, 32'd1);
    n = 0;
    while (irq_out === 1'b1 && n < 50) begin n++; tick(); end
    chk("warn_len", n, 32'd6);
    chk("reset_follows_warn", {31'b0, sys_reset_out}, 32'd1);
    n = 0;
    while (sys_reset_out === 1'b1 && n < 50) begin n++; tick(); end
    chk("pulse_len", n, 32'd3);
    rd_chk("status_holdoff", AddrStatus, 32'h0003_0101);
    tick();
    tick();
    rd_chk("holdoff_stays", AddrStatus, 32'h0003_0101);
    wdt_expired = 1'b0;
    tick();
    rd_chk("status_idle", AddrStatus, 32'h0000_0101);

    // ACK on the 4th WARN cycle with G=10
    wr(AddrStatus, 32'd0);
    rd_chk("status_clear", AddrStatus, 32'd0);
    wr(AddrGrace, 32'd10);
    wdt_expired = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("ack_pre_irq", {31'b0, irq_out}, 32'd1);
    wr(AddrAck, 32'd0);
    chk("ack_irq_drop", {31'b0, irq_out}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sys_reset_out !== 1'b0 || irq_out !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("ack_no_reset", {31'b0, seen}, 32'd0);
    rd_chk("ack_status", AddrStatus, 32'h0003_0100);
    wdt_expired = 1'b0;
    tick();

    // G=0, P=0: one WARN cycle then a one-cycle pulse
    wr(AddrGrace, 32'd0);
    wr(AddrPulse, 32'd0);
    wdt_expired = 1'b1;
    tick();
    chk("g0_irq", {irq_out, sys_reset_out}, 32'd2);
    tick();
    chk("p0_pulse", {irq_out, sys_reset_out}, 32'd1);
    tick();
    chk("p0_end", {irq_out, sys_reset_out}, 32'd0);
    rd_chk("g0_status", AddrStatus, 32'h0003_0201);
    wdt_expired = 1'b0;
    tick();

    // ACK coincides with counter reaching zero
    wr(AddrStatus, 32'd0);
    wr(AddrGrace, 32'd2);
    wdt_expired = 1'b1;
    tick();
    tick();
    tick();
    chk("zero_pre_irq", {31'b0, irq_out}, 32'd1);
    wr(AddrAck, 32'd0);
    tick();
    chk("zero_ack_wins", {irq_out, sys_reset_out}, 32'd0);
    rd_chk("zero_ack_status", AddrStatus, 32'h0003_0100);
    wdt_expired = 1'b0;
    tick();

    // No-reset mode: irq holds until ACK
    wr(AddrCtrl, 32'd1);
    wr(AddrStatus, 32'd0);
    wdt_expired = 1'b1;
    tick();
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (irq_out !== 1'b1 || sys_reset_out !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("noreset_hold", {31'b0, seen}, 32'd0);
    rd_chk("noreset_status", AddrStatus, 32'h0001_0100);
    wr(AddrAck, 32'd0);
    chk("noreset_ack", {31'b0, irq_out}, 32'd0);
    wdt_expired = 1'b0;
    tick();

    // Disable during RESET: pulse completes
    wr(AddrCtrl, 32'd3);
    wr(AddrPulse, 32'd4);
    wr(AddrGrace, 32'd0);
    wdt_expired = 1'b1;
    tick();
    tick();
    chk("dis_pulse_start", {31'b0, sys_reset_out}, 32'd1);
    wr(AddrCtrl, 32'd0);
    n = 0;
    while (sys_reset_out === 1'b1 && n < 50) begin n++; tick(); end
    chk("dis_pulse_rest", n, 32'd3);
    rd_chk("dis_status", AddrStatus, 32'h0003_0201);
    wdt_expired = 1'b0;
    tick();

    // rst asserted mid-pulse
    wr(AddrCtrl, 32'd3);
    wr(AddrPulse, 32'd5);
    wdt_expired = 1'b1;
    tick();
    tick();
    tick();
    chk("midrst_pre", {31'b0, sys_reset_out}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_outs", {irq_out, sys_reset_out}, 32'd0);
    rd_chk("midrst_ctrl", AddrCtrl, 32'd0);
    rd_chk("midrst_grace", AddrGrace, 32'd0);
    rd_chk("midrst_pulse", AddrPulse, 32'd0);
    rd_chk("midrst_status", AddrStatus, 32'd0);
    tick();
    chk("midrst_disabled", {irq_out, sys_reset_out}, 32'd0);
    wdt_expired = 1'b0;
    tick();

    // Count saturation over 256 expire/ACK rounds
    wr(AddrCtrl, 32'd1);
    for (int i = 0; i < 256; i++) begin
      wdt_expired = 1'b1;
      tick();
      wr(AddrAck, 32'd0);
      wdt_expired = 1'b0;
      tick();
    end
    rd_chk("sat_status", AddrStatus, 32'h0000_ff00);
    wr(AddrStatus, 32'd0);
    rd_chk("sat_clear", AddrStatus, 32'd0);

    // STATUS write coinciding with an increment: increment wins
    wdt_expired = 1'b1;
    wr(AddrStatus, 32'd0);
    rd_chk("clr_vs_inc", AddrStatus, 32'h0001_0100);
    wr(AddrAck, 32'd0);
    wdt_expired = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tqvp_stevej_wdt_escalator.md
# tqvp_stevej_wdt_escalator

Escalation stage directly downstream of the TinyQV watchdog peripheral. It consumes the watchdog's expired level. When enabled, it first raises a warning interrupt and waits a programmable grace period for software to acknowledge. If software does not acknowledge in time, it drives a fixed-width system reset pulse. Sticky cause and count registers let software tell after restart that a watchdog reset occurred.

## Interface
- No parameters; all limits are fixed below.
- `clk` in 1: project clock (64 MHz nominal).
- `rst` in 1: synchronous, active-high reset.
- `wdt_expired` in 1: expired level from the watchdog; stays high until the watchdog is re-armed.
- `address` in 6: register select.
- `data_in` in 32: write data.
- `data_write_n` in 2: 11 = no write; any other value = write.
- `data_read_n` in 2: unused; reads are side-effect free.
- `data_out` out 32: read data, combinational from `address`.
- `data_ready` out 1: tied to 1.
- `irq_out` out 1: warning interrupt.
- `sys_reset_out` out 1: system reset request pulse.

## Operation
- **Registers:**
  - 0x0 CTRL: bit0 `en`, bit1 `rst_en`; rest reads 0.
  - 0x1 GRACE: 32-bit grace length G.
  - 0x2 PULSE: bits[7:0] hold width P; P = 0 is treated as 1.
  - 0x3 STATUS: read returns {state[1:0] at bits 17:16, `count`[7:0] at bits 15:8, `cause` at bit 0}. Any write clears `count` and `cause`.
  - 0x4 ACK: write only; reads 0.
  - Any other address reads 0.
- **States:** IDLE, WARN, RESET, HOLDOFF.
- **IDLE:**
  - If `en` and `wdt_expired` are both high: go to WARN, load the counter with G, and increment `count`. `count` saturates at 255.
- **WARN:**
  - ACK write: go to HOLDOFF.
  - Else, counter != 0: decrement the counter.
  - Else, counter = 0 and `rst_en` = 1: go to RESET, load the counter with max(P,1), set `cause`.
  - Else, counter = 0 and `rst_en` = 0: stay in WARN until ACK.
- **RESET:**
  - Decrement the counter each cycle.
  - Counter = 1: go to HOLDOFF.
  - ACK and `en` = 0 are ignored; the pulse is never truncated.
- **HOLDOFF:**
  - Go to IDLE when `wdt_expired` = 0. This prevents re-triggering on the same expiry.
- **Disable:** writing CTRL with `en` = 0 sends WARN or HOLDOFF to IDLE on the next edge.
- **Outputs:** decoded from the state register only, so there is no combinational path from inputs.
  - `irq_out` = (state == WARN).
  - `sys_reset_out` = (state == RESET).
- **Write/read width:** all writes use the full 32-bit `data_in`, whatever the write width. Reads are always valid.

## Timing
- **Reset values:**
  - State = IDLE; CTRL = 0; GRACE = 0; PULSE = 0; `count` = 0; `cause` = 0; counter = 0.
  - `irq_out` = 0; `sys_reset_out` = 0.
  - `data_out` reflects the reset register values.
- **Trigger latency:** `wdt_expired` sampled high in IDLE with `en` = 1 makes `irq_out` high on the cycle after that edge.
- **WARN duration:** exactly G+1 cycles with no ACK. G = 0 gives one WARN cycle.
- **Reset pulse:** `sys_reset_out` is high for exactly max(P,1) consecutive cycles.
- **ACK:** an ACK write in WARN drops `irq_out` on the next cycle. If the ACK lands on the same cycle as counter = 0, ACK wins and RESET is not entered.
- **Register writes:**
  - A write to GRACE or PULSE during WARN or RESET does not affect the counter already loaded.
  - A CTRL write takes effect on the next cycle.
  - If a STATUS write coincides with an increment of `count` or a set of `cause`, the increment or set wins.
- **`rst` mid-operation:** everything returns to reset values on the next edge. This includes mid-pulse; `sys_reset_out` drops immediately after that edge.

## Structure
- **Shared package `wdt_pkg`:**
  - 2-bit state enum (IDLE = 0, WARN = 1, RESET = 2, HOLDOFF = 3).
  - Address constants 0x0–0x4.
  - PULSE width constant (8).
- **Counter:** one shared 32-bit down-counter, reused for grace and pulse.
- **Sub-modules:** none is natural; a single module.

## Test plan
- **Normal escalation:** `en` = 1, `rst_en` = 1, G = 5, P = 3; raise `wdt_expired`.
  - `irq_out` high for 6 cycles.
  - Then `sys_reset_out` high for 3 cycles.
  - Then HOLDOFF; IDLE once `wdt_expired` = 0.
  - STATUS shows `cause` = 1 and `count` = 1.
- **ACK in grace period:** G = 10; write ACK on the 4th WARN cycle.
  - `irq_out` drops the next cycle; `sys_reset_out` never rises.
  - With `wdt_expired` still high, state stays HOLDOFF; no re-trigger.
- **Boundary cases:**
  - G = 0, P = 0: one WARN cycle, then a one-cycle reset pulse.
  - ACK on the same cycle as counter = 0: no reset.
- **No-reset mode:** `rst_en` = 0, G = 2.
  - `irq_out` stays high indefinitely until ACK.
  - `cause` stays 0.
- **Disable and reset:**
  - `en` written to 0 during RESET: pulse completes its full P cycles.
  - `rst` asserted mid-pulse: all outputs 0 the next cycle, all registers 0.
- **Counter saturation:** 256 expire/ACK cycles leave `count` = 255. A STATUS write clears `count` and `cause`.
